// File: rtl/bcd_display_scanner_pkg.sv
// Shared definitions for the 7-segment display path: active-low segment codes
// ({g,f,e,d,c,b,a}) and the registered segment/DP drive payload.
package bcd_display_scanner_pkg;

  localparam int unsigned BCD_W = 4;
  localparam int unsigned SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h10;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  typedef struct packed {
    logic [SEG_W-1:0] seg;
    logic             dp;
  } seg_drive_t;

  localparam seg_drive_t DRIVE_DARK = '{seg: SEG_BLANK, dp: 1'b1};

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD digit to active-low 7-segment decode; codes 10-15 blank.
module bcd_to_7seg
  import bcd_display_scanner_pkg::*;
(
  input  logic [BCD_W-1:0] bcd,
  output logic [SEG_W-1:0] seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    case (bcd)
      4'd0:    seg_c = SEG_0;
      4'd1:    seg_c = SEG_1;
      4'd2:    seg_c = SEG_2;
      4'd3:    seg_c = SEG_3;
      4'd4:    seg_c = SEG_4;
      4'd5:    seg_c = SEG_5;
      4'd6:    seg_c = SEG_6;
      4'd7:    seg_c = SEG_7;
      4'd8:    seg_c = SEG_8;
      4'd9:    seg_c = SEG_9;
      default: seg_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed common-anode display driver: one digit per scan tick,
// frame-aligned blinking of selected digits, fixed colon DP mask.
module bcd_display_scanner
  import bcd_display_scanner_pkg::*;
#(
  parameter int unsigned           N_DIGITS     = 6,
  parameter int unsigned           SCAN_DIV     = 50000,
  parameter int unsigned           BLINK_FRAMES = 64,
  parameter logic [N_DIGITS-1:0]   DP_MASK      = 6'b010100
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [BCD_W*N_DIGITS-1:0] bcd_in,
  input  logic [N_DIGITS-1:0]       blink_mask,
  output logic [SEG_W-1:0]          seg_out,
  output logic                      dp_out,
  output logic [N_DIGITS-1:0]       digit_en
);

  localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned FRM_W = $clog2(BLINK_FRAMES) + 1;

  logic [PRE_W-1:0]    pre_cnt;
  logic [IDX_W-1:0]    idx;
  logic [FRM_W-1:0]    frame_cnt;
  logic                phase;
  seg_drive_t          drive_q;

  logic                tick_c;
  logic                frame_end_c;
  logic [BCD_W-1:0]    digit_c;
  logic                blink_sel_c;
  logic                dp_sel_c;
  logic                blank_c;
  logic [SEG_W-1:0]    seg_dec_c;

  assign tick_c      = (pre_cnt == PRE_W'(SCAN_DIV - 1));
  assign frame_end_c = tick_c && (idx == IDX_W'(N_DIGITS - 1));
  assign blank_c     = phase && blink_sel_c;

  // Digit mux on constant indices so idx never forms an out-of-range select.
  always_comb begin
    digit_c     = '0;
    blink_sel_c = 1'b0;
    dp_sel_c    = 1'b0;
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      if (idx == IDX_W'(i)) begin
        digit_c     = bcd_in[BCD_W*i +: BCD_W];
        blink_sel_c = blink_mask[i];
        dp_sel_c    = DP_MASK[i];
      end
    end
  end

  bcd_to_7seg u_dec (
    .bcd   (digit_c),
    .seg_c (seg_dec_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt   <= '0;
      idx       <= '0;
      frame_cnt <= '0;
      phase     <= 1'b0;
      drive_q   <= DRIVE_DARK;
      digit_en  <= '1;
    end else begin
      pre_cnt <= tick_c ? '0 : pre_cnt + PRE_W'(1);
      if (tick_c) begin
        digit_en    <= ~(N_DIGITS'(1) << idx);
        drive_q.seg <= blank_c ? SEG_BLANK : seg_dec_c;
        drive_q.dp  <= blank_c ? 1'b1 : ~dp_sel_c;
        idx         <= (idx == IDX_W'(N_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
      end
      // Phase only flips at frame end so a frame is never half-blanked.
      if (frame_end_c) begin
        if (frame_cnt == FRM_W'(BLINK_FRAMES - 1)) begin
          frame_cnt <= '0;
          phase     <= ~phase;
        end else begin
          frame_cnt <= frame_cnt + FRM_W'(1);
        end
      end
    end
  end

  assign seg_out = drive_q.seg;
  assign dp_out  = drive_q.dp;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench for bcd_display_scanner with SCAN_DIV=4, BLINK_FRAMES=2.
module tb_bcd_display_scanner;

  logic        clk;
  logic        rst;
  logic [23:0] bcd_in;
  logic [5:0]  blink_mask;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [5:0]  digit_en;

  int checks   = 0;
  int failures = 0;

  logic [5:0] cur_en;
  logic [6:0] cur_seg;
  logic       cur_dp;

  typedef struct {
    logic [23:0] bcd;
    logic [5:0]  mask;
    bit          glitch;
    logic [5:0]  en;
    logic [6:0]  seg;
    logic        dp;
  } vec_t;

  vec_t vecs[$];

  bcd_display_scanner #(
    .N_DIGITS     (6),
    .SCAN_DIV     (4),
    .BLINK_FRAMES (2),
    .DP_MASK      (6'b010100)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bcd_in     (bcd_in),
    .blink_mask (blink_mask),
    .seg_out    (seg_out),
    .dp_out     (dp_out),
    .digit_en   (digit_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, ".digit_en"}, {2'b00, digit_en}, {2'b00, cur_en});
    chk({tag, ".seg_out"},  {1'b0, seg_out},   {1'b0, cur_seg});
    chk({tag, ".dp_out"},   {7'b0, dp_out},    {7'b0, cur_dp});
  endtask

  // One scan slot: three hold cycles then the tick edge; optional junk inputs
  // during the first two cycles must stay invisible.
  task automatic run_tick(input vec_t v, input int n);
    for (int c = 0; c < 4; c++) begin
      if (v.glitch && c < 2) begin
        bcd_in     = ~v.bcd;
        blink_mask = ~v.mask;
      end else begin
        bcd_in     = v.bcd;
        blink_mask = v.mask;
      end
      step();
      if (c == 3) begin
        cur_en  = v.en;
        cur_seg = v.seg;
        cur_dp  = v.dp;
        chk_outputs($sformatf("tick%0d", n));
      end else begin
        chk_outputs($sformatf("hold%0d_%0d", n, c));
      end
    end
  endtask

  logic [6:0] code_123456 [6];
  logic [6:0] code_12c456 [6];
  logic       dp_lit      [6];

  initial begin
    vec_t v;
    bit   blank;

    code_123456 = '{7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79};
    code_12c456 = '{7'h02, 7'h12, 7'h19, 7'h7F, 7'h24, 7'h79};
    dp_lit      = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    // Frames 0..5: scan then blink of digits 0,1 (phase 1 in frames 2-3).
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < 6; i++) begin
        v.bcd    = 24'h123456;
        v.mask   = (f == 0) ? 6'b000000 : 6'b000011;
        v.glitch = 1'b0;
        v.en     = ~(6'b000001 << i);
        blank    = (((f / 2) % 2) == 1) && v.mask[i];
        v.seg    = blank ? 7'h7F : code_123456[i];
        v.dp     = blank ? 1'b1 : ~dp_lit[i];
        vecs.push_back(v);
      end
    end
    // Frame 6: invalid code on digit 3.
    for (int i = 0; i < 6; i++) begin
      v.bcd    = 24'h12C456;
      v.mask   = 6'b000000;
      v.glitch = 1'b0;
      v.en     = ~(6'b000001 << i);
      v.seg    = code_12c456[i];
      v.dp     = ~dp_lit[i];
      vecs.push_back(v);
    end
    // Frame 7 digits 0-3: phase 1, inputs glitched between ticks.
    for (int i = 0; i < 4; i++) begin
      v.bcd    = 24'h123456;
      v.mask   = 6'b000011;
      v.glitch = 1'b1;
      v.en     = ~(6'b000001 << i);
      blank    = v.mask[i];
      v.seg    = blank ? 7'h7F : code_123456[i];
      v.dp     = blank ? 1'b1 : ~dp_lit[i];
      vecs.push_back(v);
    end

    rst        = 1'b1;
    bcd_in     = 24'h123456;
    blink_mask = 6'b000000;
    cur_en     = 6'b111111;
    cur_seg    = 7'h7F;
    cur_dp     = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk_outputs($sformatf("reset%0d", c));
    end
    rst = 1'b0;

    for (int n = 0; n < vecs.size(); n++) run_tick(vecs[n], n);

    // Mid-scan reset with idx=4 pending and phase=1.
    rst = 1'b1;
    step();
    rst = 1'b0;
    cur_en  = 6'b111111;
    cur_seg = 7'h7F;
    cur_dp  = 1'b1;
    chk_outputs("midrst");

    v.bcd = 24'h123456; v.mask = 6'b000011; v.glitch = 1'b0;
    v.en = 6'b111110; v.seg = 7'h02; v.dp = 1'b1;
    run_tick(v, 100);
    v.en = 6'b111101; v.seg = 7'h12; v.dp = 1'b1;
    run_tick(v, 101);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
